// File: rtl/tea_sequencer.sv
// TEA round sequencer: walks IDLE/INIT/SUM/CALC/UPDATE/DONE and drives the running
// sum, round index and per-round datapath strobes for encrypt or decrypt.
module tea_sequencer #(
   parameter int unsigned ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        mode,
   input  logic        abort,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] sum,
   output logic [5:0]  round_idx,
   output logic        ld_results,
   output logic        ld_v_enc,
   output logic        ld_v_dec
);

   localparam logic [31:0] SUM_DEC  = 32'(64'(DELTA) * 64'(ROUNDS));
   localparam logic [5:0]  LAST_IDX = 6'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SUM,
      S_CALC,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        mode_q, mode_d;
   logic [31:0] sum_q, sum_d;
   logic [5:0]  idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         sum_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            sum_d   = mode_q ? SUM_DEC : '0;
            idx_d   = '0;
            state_d = mode_q ? S_CALC : S_SUM;
         end
         // Decrypt closes each round in SUM; encrypt closes it in UPDATE.
         S_SUM: begin
            if (!mode_q) begin
               sum_d   = sum_q + DELTA;
               state_d = S_CALC;
            end else begin
               sum_d = sum_q - DELTA;
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 6'd1;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: state_d = S_UPDATE;
         S_UPDATE: begin
            if (mode_q) begin
               state_d = S_SUM;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 6'd1;
               state_d = S_SUM;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Abort overrides whatever the case chose, keeping sum and index as they were.
      if (abort && state_q != S_IDLE && state_q != S_DONE) begin
         state_d = S_IDLE;
         sum_d   = sum_q;
         idx_d   = idx_q;
      end
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
      ld_results = (state_q == S_CALC);
      ld_v_enc   = (state_q == S_UPDATE) && !mode_q;
      ld_v_dec   = (state_q == S_UPDATE) && mode_q;
      sum        = sum_q;
      round_idx  = idx_q;
   end

endmodule

// File: tb/tb_tea_sequencer.sv
// Randomized bench for tea_sequencer: an operation timeline model predicts the
// strobes, running sum and round index on every cycle.
module tb_tea_sequencer;

   localparam int unsigned R = 32;
   localparam logic [31:0] D = 32'h9E3779B9;
   localparam int          TOTAL = 1 + 3 * int'(R);

   logic        clk = 1'b0;
   logic        resetn, start, mode, abort, out_ready;
   logic        busy, done, ld_results, ld_v_enc, ld_v_dec;
   logic [31:0] sum;
   logic [5:0]  round_idx;

   int n_checks = 0;
   int n_err    = 0;

   tea_sequencer #(
      .ROUNDS(R),
      .DELTA (D)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .mode      (mode),
      .abort     (abort),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .round_idx (round_idx),
      .ld_results(ld_results),
      .ld_v_enc  (ld_v_enc),
      .ld_v_dec  (ld_v_dec)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] outs_now();
      return {busy, done, ld_results, ld_v_enc, ld_v_dec};
   endfunction

   // Observation j edges after the start edge: j=0 INIT, then three states per
   // round, j=TOTAL is DONE. Sum follows DELTA multiples of the rounds completed.
   function automatic void model(input logic m, input int j, output logic [4:0] tr,
                                 output logic [31:0] s, output logic [5:0] ix, output logic csi);
      int p, r;
      tr  = 5'b10000;
      s   = '0;
      ix  = '0;
      csi = 1'b1;
      if (j == 0) begin
         csi = 1'b0;
      end else if (j == TOTAL) begin
         tr = 5'b11000;
         s  = m ? 32'h0 : D * R;
         ix = 6'(R - 1);
      end else begin
         p  = (j - 1) % 3;
         r  = (j - 1) / 3;
         ix = 6'(r);
         if (!m) begin
            case (p)
               0:       begin tr = 5'b10000; s = D * 32'(r);     end
               1:       begin tr = 5'b10100; s = D * 32'(r + 1); end
               default: begin tr = 5'b10010; s = D * 32'(r + 1); end
            endcase
         end else begin
            s = D * (R - 32'(r));
            case (p)
               0:       tr = 5'b10100;
               1:       tr = 5'b10001;
               default: tr = 5'b10000;
            endcase
         end
      end
   endfunction

   task automatic run_op(input logic m, input int abort_r, input int rst_r, input int hold);
      logic [4:0]  tr;
      logic [31:0] es;
      logic [5:0]  ei;
      logic        csi;
      int n_res = 0, n_upd = 0, n_bad = 0;
      start = 1'b1; mode = m; abort = 1'b0; out_ready = 1'($urandom_range(0, 1));
      tick();
      for (int j = 0; j <= TOTAL; j++) begin
         model(m, j, tr, es, ei, csi);
         check_eq("trace", 64'(outs_now()), 64'(tr));
         if (csi) begin
            check_eq("sum", 64'(sum), 64'(es));
            check_eq("round_idx", 64'(round_idx), 64'(ei));
         end
         if (ld_results) n_res++;
         if (m ? ld_v_dec : ld_v_enc) n_upd++;
         if (m ? ld_v_enc : ld_v_dec) n_bad++;
         if (j == TOTAL) break;
         start     = 1'($urandom_range(0, 1));
         mode      = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         abort     = 1'b0;
         if (tr[2] && int'(ei) == abort_r) begin
            abort = 1'b1;
            tick();
            abort = 1'b0; start = 1'b0;
            check_eq("abort_idle", 64'(outs_now()), 64'(0));
            check_eq("abort_sum", 64'(sum), 64'(es));
            check_eq("abort_idx", 64'(round_idx), 64'(ei));
            repeat (3) begin
               tick();
               check_eq("abort_no_done", 64'(outs_now()), 64'(0));
            end
            return;
         end
         if (j > 0 && (j - 1) % 3 == 0 && int'(ei) == rst_r) begin
            resetn = 1'b0; abort = 1'b1;
            tick();
            resetn = 1'b1; start = 1'b0; abort = 1'b0;
            check_eq("rst_outs", 64'(outs_now()), 64'(0));
            check_eq("rst_sum", 64'(sum), 64'(0));
            check_eq("rst_idx", 64'(round_idx), 64'(0));
            tick();
            check_eq("rst_stay_idle", 64'(outs_now()), 64'(0));
            return;
         end
         tick();
      end
      check_eq("n_ld_results", 64'(n_res), 64'(R));
      check_eq("n_ld_update", 64'(n_upd), 64'(R));
      check_eq("n_ld_wrong", 64'(n_bad), 64'(0));
      check_eq("final_sum", 64'(sum), m ? 64'h0 : 64'hC6EF3720);
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         start = 1'($urandom_range(0, 1));
         mode  = 1'($urandom_range(0, 1));
         abort = 1'($urandom_range(0, 1));
         tick();
         check_eq("hold_outs", 64'(outs_now()), 64'(5'b11000));
         check_eq("hold_sum", 64'(sum), 64'(es));
         check_eq("hold_idx", 64'(round_idx), 64'(ei));
      end
      out_ready = 1'b1; start = 1'b1; abort = 1'($urandom_range(0, 1));
      tick();
      check_eq("ack_idle", 64'(outs_now()), 64'(0));
      start = 1'b0; out_ready = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
      tick();
      check_eq("ack_start_ignored", 64'(outs_now()), 64'(0));
      out_ready = 1'b0; abort = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; start = 1'b1; mode = 1'b1; abort = 1'b1; out_ready = 1'b1;
      tick();
      tick();
      check_eq("reset_outs", 64'(outs_now()), 64'(0));
      check_eq("reset_sum", 64'(sum), 64'(0));
      check_eq("reset_idx", 64'(round_idx), 64'(0));
      resetn = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b1; out_ready = 1'b1;
      tick();
      check_eq("idle_abort_ack_ignored", 64'(outs_now()), 64'(0));
      abort = 1'b0; out_ready = 1'b0;

      run_op(1'b0, -1, -1, 10);
      run_op(1'b1, -1, -1, int'($urandom_range(0, 5)));
      run_op(1'($urandom_range(0, 1)), 10, -1, 0);
      run_op(1'b1, -1, 5, 0);
      run_op(1'b0, -1, -1, 2);
      repeat (6) begin
         run_op(1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, R - 1)) : -1,
                -1, int'($urandom_range(0, 4)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
